// File: rtl/rs_pkg.sv
// Shared widths, entry field offsets, wake-bus type and operand wakeup helper
// for the 2-entry simple reservation station.
package rs_pkg;
    localparam int ENTRY_W = 114;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;

    localparam int S1_VALID   = 5;
    localparam int S1_LSB     = 6;
    localparam int S2_VALID   = 38;
    localparam int S2_LSB     = 39;
    localparam int REGWRITE   = 71;
    localparam int ALUOP_LSB  = 76;
    localparam int S1_TAG_LSB = 81;
    localparam int S2_TAG_LSB = 85;

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        data_t data;
    } wake_bus_t;

    // Fill any not-yet-ready operand from a matching bus; bus 0 has priority.
    function automatic entry_t wake_entry(entry_t e, wake_bus_t b0, wake_bus_t b1);
        entry_t r;
        r = e;
        if (!e[S1_VALID]) begin
            if (b0.valid && (b0.tag == e[S1_TAG_LSB +: TAG_W])) begin
                r[S1_LSB +: DATA_W] = b0.data;
                r[S1_VALID]         = 1'b1;
            end else if (b1.valid && (b1.tag == e[S1_TAG_LSB +: TAG_W])) begin
                r[S1_LSB +: DATA_W] = b1.data;
                r[S1_VALID]         = 1'b1;
            end
        end
        if (!e[S2_VALID]) begin
            if (b0.valid && (b0.tag == e[S2_TAG_LSB +: TAG_W])) begin
                r[S2_LSB +: DATA_W] = b0.data;
                r[S2_VALID]         = 1'b1;
            end else if (b1.valid && (b1.tag == e[S2_TAG_LSB +: TAG_W])) begin
                r[S2_LSB +: DATA_W] = b1.data;
                r[S2_VALID]         = 1'b1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/rs_simple_if.sv
// Dispatch, wakeup, issue and slot-output signals between the reservation
// station (slave) and its dispatch/executor neighbours (master).
interface rs_simple_if;
    import rs_pkg::*;

    logic   flush;
    logic   dispatch_valid;
    entry_t dispatch_inst;
    tag_t   dispatch_rob_num;
    logic   rs_full;
    logic   wb0_valid;
    tag_t   wb0_tag;
    data_t  wb0_data;
    logic   wb1_valid;
    tag_t   wb1_tag;
    data_t  wb1_data;
    logic   simple_0_issue;
    logic   simple_1_issue;
    entry_t rs_simple_0;
    entry_t rs_simple_1;
    tag_t   rs_simple_0_entry_num;
    tag_t   rs_simple_1_entry_num;
    logic   selector;

    modport master (
        output flush, dispatch_valid, dispatch_inst, dispatch_rob_num,
        output wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data,
        output simple_0_issue, simple_1_issue,
        input  rs_full, rs_simple_0, rs_simple_1,
        input  rs_simple_0_entry_num, rs_simple_1_entry_num, selector
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_inst, dispatch_rob_num,
        input  wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data,
        input  simple_0_issue, simple_1_issue,
        output rs_full, rs_simple_0, rs_simple_1,
        output rs_simple_0_entry_num, rs_simple_1_entry_num, selector
    );
endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: valid bit, payload, ROB number and two-bus wakeup.
// Macro RS_SIMPLE_BYPASS_EN makes the output show same-cycle wakeups.
module rs_entry
    import rs_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      load,
    input  entry_t    load_inst,
    input  tag_t      load_rob,
    input  logic      issue,
    input  wake_bus_t wb0,
    input  wake_bus_t wb1,
    output logic      valid,
    output entry_t    entry,
    output tag_t      entry_num
);
    logic   valid_reg, valid_next;
    entry_t payload_reg, payload_next;
    tag_t   rob_reg, rob_next;
    entry_t woken;

    assign woken = wake_entry(payload_reg, wb0, wb1);

    always_comb begin
        valid_next   = valid_reg;
        payload_next = payload_reg;
        rob_next     = rob_reg;
        if (load) begin
            valid_next   = 1'b1;
            payload_next = wake_entry(load_inst, wb0, wb1);
            rob_next     = load_rob;
        end else if (valid_reg) begin
            if (issue) begin
                valid_next   = 1'b0;
                payload_next = '0;
                rob_next     = '0;
            end else begin
                payload_next = woken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_reg   <= 1'b0;
            payload_reg <= '0;
            rob_reg     <= '0;
        end else begin
            valid_reg   <= valid_next;
            payload_reg <= payload_next;
            rob_reg     <= rob_next;
        end
    end

    assign valid     = valid_reg;
    assign entry_num = valid_reg ? rob_reg : '0;
`ifdef RS_SIMPLE_BYPASS_EN
    assign entry = valid_reg ? woken : '0;
`else
    assign entry = valid_reg ? payload_reg : '0;
`endif
endmodule

// File: rtl/rs_simple.sv
// 2-entry reservation station for the simple FU: allocation, age selector, full, flush.
// Optional macro RS_SIMPLE_BYPASS_EN enables same-cycle wakeup on the slot outputs.
module rs_simple
    import rs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    rs_simple_if.slave  bus
);
    logic [1:0] slot_valid;
    logic [1:0] slot_load;
    logic [1:0] slot_issue;
    entry_t     slot_entry [2];
    tag_t       slot_num   [2];
    wake_bus_t  wb0, wb1;
    logic       accept;
    logic       selector_reg, selector_next;

    assign wb0 = '{valid: bus.wb0_valid, tag: bus.wb0_tag, data: bus.wb0_data};
    assign wb1 = '{valid: bus.wb1_valid, tag: bus.wb1_tag, data: bus.wb1_data};

    assign bus.rs_full = &slot_valid;
    assign accept      = bus.dispatch_valid && !(&slot_valid);
    // Slot 0 is preferred; slot 1 only when slot 0 is already occupied.
    assign slot_load[0] = accept && !slot_valid[0];
    assign slot_load[1] = accept &&  slot_valid[0];
    assign slot_issue   = {bus.simple_1_issue, bus.simple_0_issue};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            rs_entry u_entry (
                .clk       (clk),
                .rst       (rst),
                .flush     (bus.flush),
                .load      (slot_load[gi]),
                .load_inst (bus.dispatch_inst),
                .load_rob  (bus.dispatch_rob_num),
                .issue     (slot_issue[gi]),
                .wb0       (wb0),
                .wb1       (wb1),
                .valid     (slot_valid[gi]),
                .entry     (slot_entry[gi]),
                .entry_num (slot_num[gi])
            );
        end
    endgenerate

    always_comb begin
        selector_next = selector_reg;
        if (accept) begin
            selector_next = slot_load[1];
        end else if (slot_issue[0] && slot_valid[0] && slot_valid[1] && !slot_issue[1]) begin
            selector_next = 1'b1;
        end else if (slot_issue[1] && slot_valid[1] && slot_valid[0] && !slot_issue[0]) begin
            selector_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            selector_reg <= 1'b0;
        end else begin
            selector_reg <= selector_next;
        end
    end

    assign bus.selector              = selector_reg;
    assign bus.rs_simple_0           = slot_entry[0];
    assign bus.rs_simple_1           = slot_entry[1];
    assign bus.rs_simple_0_entry_num = slot_num[0];
    assign bus.rs_simple_1_entry_num = slot_num[1];
endmodule
